// File: rtl/alu_sequencer.sv
// Multi-cycle ALU execution controller: captures one opcode plus operands, runs
// add/sub/logic in one execute cycle or shifts one bit per cycle, then pulses done.
module alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       ALUop,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic [1:0]       fsm_state
);

    // Handshake: start is a level sampled only in IDLE; a request is taken on
    // the edge where state==IDLE and start==1, done is high for the single
    // DONE cycle, and start is ignored everywhere else (nothing is queued).

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [7:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] shifted;
    logic             shift_out;
    logic             fill;
    logic             finish;
    logic [WIDTH-1:0] fin_val;
    logic             fin_carry;

    always_comb begin
        next_state = state;
        finish     = 1'b0;
        fin_val    = '0;
        fin_carry  = 1'b0;

        // isTwoC turns the adder into A + ~B + 1; bit WIDTH is the no-borrow carry.
        sum       = {1'b0, a_q} + {1'b0, (op_q[6] ? ~b_q : b_q)} + {{WIDTH{1'b0}}, op_q[6]};
        fill      = op_q[7] & acc[WIDTH-1];
        shifted   = op_q[5] ? {acc[WIDTH-2:0], 1'b0} : {fill, acc[WIDTH-1:1]};
        shift_out = op_q[5] ? acc[WIDTH-1] : acc[0];

        case (state)
            S_IDLE: begin
                if (start) next_state = S_EXEC;
            end
            S_EXEC: begin
                if (op_q[4:3] != 2'b11) begin
                    next_state = S_DONE;
                    finish     = 1'b1;
                    case (op_q[4:3])
                        2'b00: begin
                            fin_val   = sum[WIDTH-1:0];
                            fin_carry = sum[WIDTH];
                        end
                        2'b01:   fin_val = a_q & b_q;
                        default: fin_val = a_q ^ b_q;
                    endcase
                end else if (b_q[SHW-1:0] == '0) begin
                    next_state = S_DONE;
                    finish     = 1'b1;
                    fin_val    = a_q;
                end else begin
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The last shift writes its value straight into result on the DONE edge.
                if (cnt == SHW'(1)) begin
                    next_state = S_DONE;
                    finish     = 1'b1;
                    fin_val    = shifted;
                    fin_carry  = shift_out;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            sign   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && start) begin
                op_q <= ALUop;
                a_q  <= opA;
                b_q  <= opB;
            end
            if (state == S_EXEC) begin
                acc <= a_q;
                cnt <= b_q[SHW-1:0];
            end
            if (state == S_SHIFT) begin
                acc <= shifted;
                cnt <= cnt - SHW'(1);
            end
            if (finish) begin
                result <= fin_val;
                if (op_q[0]) carry <= fin_carry;
                if (op_q[1]) zero  <= (fin_val == '0);
                if (op_q[2]) sign  <= fin_val[WIDTH-1];
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus random bench for alu_sequencer with a reference model feeding
// an expected-result scoreboard.
module tb_alu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   ALUop = '0;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         sign;
    logic [1:0]   fsm_state;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int done_count = 0;

    logic [W-1:0] exp_q[$];
    logic [2:0]   exp_flag_q[$];
    int           exp_lat_q[$];

    logic m_carry = 1'b0;
    logic m_zero  = 1'b0;
    logic m_sign  = 1'b0;

    alu_sequencer #(.WIDTH(W), .SHW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUop(ALUop), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
        .sign(sign), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-word shifts, compare-based borrow.
    task automatic push_expected(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [W:0]   s;
        logic         c;
        int           n;
        n = int'(b[4:0]);
        c = 1'b0;
        case (op[4:3])
            2'b00: begin
                if (op[6]) begin
                    r = a - b;
                    c = (a >= b);
                end else begin
                    s = {1'b0, a} + {1'b0, b};
                    r = s[W-1:0];
                    c = s[W];
                end
            end
            2'b01: r = a & b;
            2'b10: r = a ^ b;
            default: begin
                if (op[5]) begin
                    r = a << n;
                    if (n != 0) c = a[W-n];
                end else begin
                    if (op[7]) r = $signed(a) >>> n;
                    else       r = a >> n;
                    if (n != 0) c = a[n-1];
                end
            end
        endcase
        if (op[0]) m_carry = c;
        if (op[1]) m_zero  = (r == '0);
        if (op[2]) m_sign  = r[W-1];
        exp_q.push_back(r);
        exp_flag_q.push_back({m_sign, m_zero, m_carry});
        exp_lat_q.push_back((op[4:3] == 2'b11) ? 2 + n : 2);
    endtask

    // Called #1 after an edge; leaves start high only when hold is set.
    task automatic drive(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        push_expected(op, a, b);
        ALUop = op;
        opA   = a;
        opB   = b;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        edges = 1;
        done_count = 0;
        check("busy_after_e0", busy, 1'b1);
    endtask

    task automatic wait_done();
        logic [W-1:0] er;
        logic [2:0]   ef;
        int           el;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            check("busy_running", busy, 1'b1);
        end
        start = 1'b0;
        check("done_seen", done, 1'b1);
        er = exp_q.pop_front();
        ef = exp_flag_q.pop_front();
        el = exp_lat_q.pop_front();
        check("latency", W'(edges), W'(el));
        check("result", result, er);
        check("flags_szc", W'({sign, zero, carry}), W'(ef));
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    task automatic run_op(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        drive(op, a, b, 1'b0);
        wait_done();
    endtask

    initial begin
        logic [7:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, '0);
        check("reset_flags", W'({sign, zero, carry}), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD with all flags enabled.
        run_op(8'b00000111, 32'd5, 32'd7);
        check("add_value", result, 32'd12);

        // SUB of equal operands, then SUB with flags frozen.
        run_op(8'b01000011, 32'h10, 32'h10);
        check("sub_eq_carry", W'(carry), 1);
        check("sub_eq_zero", W'(zero), 1);
        run_op(8'b01000000, 32'd1, 32'd2);
        check("sub_neg_value", result, 32'hFFFF_FFFF);

        // AND / XOR.
        run_op(8'b00001111, 32'hF0F0_1234, 32'h0FF0_FF00);
        run_op(8'b00010110, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        // Arithmetic right shift by 4.
        run_op(8'b10011111, 32'h8000_0001, 32'd4);
        check("asr_value", result, 32'hF800_0000);

        // Left shift by 1 and by 0.
        run_op(8'b00111001, 32'h8000_0000, 32'd1);
        check("shl_carry", W'(carry), 1);
        run_op(8'b00111001, 32'h8000_0000, 32'd0);
        check("shl0_value", result, 32'h8000_0000);

        // Logical right shift by 31, and an ignored isArith on left shift.
        run_op(8'b00011111, 32'h8000_0000, 32'd31);
        run_op(8'b10111111, 32'h4000_0001, 32'd2);

        // start held high through a 10-cycle shift with operands changing mid-op.
        drive(8'b00011111, 32'hF0F0_F0F0, 32'd8, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            edges++;
            check("busy_hold", busy, 1'b1);
        end
        opA = 32'h1234_5678;
        opB = 32'd3;
        wait_done();
        check("hold_value", result, 32'h00F0_F0F0);
        repeat (4) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_count++;
        end
        check("hold_no_extra_done", W'(done_count), 0);
        check("hold_idle", busy, 1'b0);

        // Reset during SHIFT.
        drive(8'b00111111, 32'h0000_0003, 32'd20, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_state_shift", W'(fsm_state), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        void'(exp_flag_q.pop_back());
        void'(exp_lat_q.pop_back());
        m_carry = 1'b0;
        m_zero  = 1'b0;
        m_sign  = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, '0);
        check("rst_flags", W'({sign, zero, carry}), '0);
        done_count = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_count++;
        end
        check("rst_no_done", W'(done_count), 0);

        // Random opcodes and operands.
        for (int i = 0; i < 16; i++) begin
            rop = 8'($urandom_range(0, 255));
            ra  = $urandom();
            rb  = $urandom();
            if (i % 4 == 0) rb = ra;
            run_op(rop, ra, rb);
        end

        check("queue_empty", W'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execution controller that accepts one 8-bit ALU opcode plus two operands per request and sequences the operation to completion. It decodes the opcode fields itself: isArith, isTwoC, LeftOrRight, Operation and SetFlag. Add, subtract and logic operations take a single execute cycle. Shifts iterate one bit per cycle, up to the shift amount. The block sits between the instruction decode/issue stage and the register write-back and flag registers: it raises `busy` while working and pulses `done` with a registered result and updated flags.

## Interface
- `WIDTH`, 32, operand/result width in bits.
- `SHW`, 5, shift-amount width; shift amount is `opB[SHW-1:0]`.

- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request strobe; sampled only in IDLE.
- `ALUop`  input  8  opcode fields:
  - [7] isArith; [6] isTwoC; [5] LeftOrRight.
  - [4:3] Operation; [2:0] SetFlag.
- `opA`  input  WIDTH  first operand.
- `opB`  input  WIDTH  second operand, or shift amount in its low SHW bits.
- `busy`  output  1  high in EXEC, SHIFT and DONE.
- `done`  output  1  one-cycle completion pulse.
- `result`  output  WIDTH  registered result; holds until the next completion.
- `carry`, `zero`, `sign`  output  1 each  registered flags.

## Operation
- **States:**
  - IDLE: `start`=1 captures `ALUop`, `opA`, `opB` into internal registers → EXEC.
  - EXEC:
    - Operation≠11: computes the result → DONE.
    - Operation=11: loads acc=A and cnt=B[SHW-1:0]. If cnt=0 → DONE; else → SHIFT.
  - SHIFT: shifts acc one bit, decrements cnt, records the bit shifted out. When cnt reaches 0 → DONE.
  - DONE: `done`=1 → IDLE.
- **Operation decode:**
  - 00: ADD (A+B); with isTwoC=1, SUB (A+~B+1).
  - 01: AND.
  - 10: XOR.
  - 11: SHIFT. LeftOrRight=1 shifts left with zero fill. LeftOrRight=0 shifts right; fill is A's MSB if isArith=1, else 0. isArith is ignored for left shifts and non-shift operations. isTwoC is ignored except for Operation 00.
- **Width rules:**
  - ADD/SUB computed in WIDTH+1 bits; `result` is the low WIDTH bits.
  - Carry candidate for ADD/SUB is bit WIDTH of the sum. For SUB this means carry=1 when A≥B unsigned (no borrow).
  - Carry candidate for SHIFT is the last bit shifted out; for shift amount 0 it is 0.
  - Carry candidate for AND/XOR is 0.
- **Flag update:** `result` and the flags are written on the edge entering DONE.
  - SetFlag[0]=1 → `carry` takes the candidate.
  - SetFlag[1]=1 → `zero` = (result==0).
  - SetFlag[2]=1 → `sign` = result[WIDTH-1].
  - A flag whose SetFlag bit is 0 holds its old value.
- **Start rules:**
  - `start` outside IDLE is ignored; nothing is queued.
  - Captured operands are immune to input changes after capture.
- **Reset:** IDLE; `busy`=0, `done`=0, `result`=0, `carry`=`zero`=`sign`=0. Reset mid-operation aborts with no `done` pulse.

## Timing
- Let edge E0 be the edge that samples `start`.
  - `busy` is high from after E0 until the edge leaving DONE.
  - Non-shift: `done` and the new `result` are visible in the cycle after E1, i.e. latency 2.
  - Shift by n: latency 2+n (n=0 gives 2; n=31 gives 33).
- `done` is high for exactly one cycle.
- A new `start` is accepted the cycle after `done`, so back-to-back non-shift throughput is one operation per 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **ADD with flags.** ALUop=8'b00000111, A=5, B=7, `start` at E0 → `done` after E1; `result`=12; carry=0, zero=0, sign=0.
- **SUB, equal operands.** ALUop=8'b01000011, A=B=0x10 → `result`=0, zero=1, carry=1 (no borrow). Then ALUop=8'b01000000 with A=1, B=2 → `result`=0xFFFFFFFF; all flags unchanged from the previous operation.
- **Arithmetic right shift.** ALUop=8'b10011111, A=0x80000001, B=4 → `busy` for 6 cycles, `done` at latency 6; `result`=0xF8000000; carry=0 (last bit out is bit 3); sign=1.
- **Left shift, carry and zero-amount.** ALUop=8'b00111001, A=0x80000000, B=1 → `result`=0, carry=1. Same op with B=0 → latency 2, `result`=A, carry=0.
- **Ignored start and operand stability.** `start` held high during a 10-cycle shift, with `opA` changed mid-op → exactly one `done`; result uses the captured A; the next request is accepted only from IDLE.
- **Reset mid-operation.** `rst` during SHIFT → next cycle `busy`=0, `result`=0, all flags 0, no `done` pulse.
